// File: rtl/ur408_pkg.sv
// Shared definitions for the UR408 sequencer: state encoding and datapath widths.
package ur408_pkg;

  localparam int unsigned UR408_XLEN = 16;

  // PC increment between sequential instructions (bytes).
  localparam logic [UR408_XLEN-1:0] UR408_ILEN = 16'd2;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    TRAP  = 2'd3
  } ur408_state_e;

endpackage

// File: rtl/ur408_next_pc.sv
// Combinational next-PC selection for a committing non-memory instruction.
module ur408_next_pc
  import ur408_pkg::*;
(
  input  logic [15:0] pc,
  input  logic        dec_ret,
  input  logic        dec_jmp,
  input  logic        dec_bra,
  input  logic        cmp_true,
  input  logic [15:0] branch_offset,
  input  logic [15:0] jmp_target,
  input  logic [15:0] epc_in,
  output logic [15:0] next_pc
);

  // Priority: return, jump, taken branch, sequential; all sums wrap mod 2^16.
  always_comb begin
    next_pc = pc + UR408_ILEN;
    if (dec_ret) begin
      next_pc = epc_in;
    end else if (dec_jmp) begin
      next_pc = jmp_target;
    end else if (dec_bra && cmp_true) begin
      next_pc = pc + branch_offset;
    end
  end

endmodule

// File: rtl/ur408_seq.sv
// UR408 instruction sequencer: fetch/exec/mem/trap FSM owning PC and IR.
module ur408_seq
  import ur408_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ibus_req,
  output logic [15:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [15:0] ibus_rdata,
  output logic [15:0] ir,
  output logic [15:0] pc,
  input  logic        dec_mem_read,
  input  logic        dec_mem_write,
  input  logic        dec_bra,
  input  logic        dec_jmp,
  input  logic        dec_ret,
  input  logic        dec_cr_write,
  input  logic        dec_gpr_write,
  input  logic [15:0] branch_offset,
  input  logic        cmp_true,
  input  logic [15:0] jmp_target,
  input  logic [15:0] epc_in,
  input  logic [15:0] tvec,
  input  logic        irq,
  input  logic        irq_en,
  output logic        dbus_req,
  output logic        dbus_we,
  input  logic        dbus_ack,
  output logic        gpr_we,
  output logic        cr_we,
  output logic        epc_we,
  output logic [15:0] epc_out,
  output logic        irq_ack
);

  ur408_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  ir_q, ir_d;
  logic [15:0]  next_pc;
  logic         take_irq;

  ur408_next_pc u_next_pc (
    .pc            (pc_q),
    .dec_ret       (dec_ret),
    .dec_jmp       (dec_jmp),
    .dec_bra       (dec_bra),
    .cmp_true      (cmp_true),
    .branch_offset (branch_offset),
    .jmp_target    (jmp_target),
    .epc_in        (epc_in),
    .next_pc       (next_pc)
  );

  assign take_irq  = irq & irq_en;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign ibus_addr = pc_q;
  assign epc_out   = pc_q;

  // State, PC and IR registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, bus handshakes and one-cycle commit strobes.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ibus_req = 1'b0;
    dbus_req = 1'b0;
    dbus_we  = 1'b0;
    gpr_we   = 1'b0;
    cr_we    = 1'b0;
    epc_we   = 1'b0;
    irq_ack  = 1'b0;
    case (state_q)
      FETCH: begin
        // Reset parks the FSM in FETCH; gating with rst_n keeps the request low while held.
        ibus_req = rst_n;
        if (ibus_ack) begin
          ir_d    = ibus_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (dec_mem_read || dec_mem_write) begin
          state_d = MEM;
        end else begin
          gpr_we  = dec_gpr_write;
          cr_we   = dec_cr_write;
          pc_d    = next_pc;
          state_d = take_irq ? TRAP : FETCH;
        end
      end
      MEM: begin
        dbus_req = 1'b1;
        dbus_we  = dec_mem_write;
        if (dbus_ack) begin
          gpr_we  = dec_mem_read;
          pc_d    = pc_q + UR408_ILEN;
          state_d = take_irq ? TRAP : FETCH;
        end
      end
      TRAP: begin
        epc_we  = 1'b1;
        irq_ack = 1'b1;
        pc_d    = tvec;
        state_d = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_ur408_seq.sv
// Directed self-checking bench for ur408_seq.
module tb_ur408_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ibus_req;
  logic [15:0] ibus_addr;
  logic        ibus_ack = 1'b0;
  logic [15:0] ibus_rdata = '0;
  logic [15:0] ir;
  logic [15:0] pc;
  logic        dec_mem_read = 1'b0;
  logic        dec_mem_write = 1'b0;
  logic        dec_bra = 1'b0;
  logic        dec_jmp = 1'b0;
  logic        dec_ret = 1'b0;
  logic        dec_cr_write = 1'b0;
  logic        dec_gpr_write = 1'b0;
  logic [15:0] branch_offset = '0;
  logic        cmp_true = 1'b0;
  logic [15:0] jmp_target = '0;
  logic [15:0] epc_in = '0;
  logic [15:0] tvec = 16'h0040;
  logic        irq = 1'b0;
  logic        irq_en = 1'b0;
  logic        dbus_req;
  logic        dbus_we;
  logic        dbus_ack = 1'b0;
  logic        gpr_we;
  logic        cr_we;
  logic        epc_we;
  logic [15:0] epc_out;
  logic        irq_ack;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ur408_seq #(.RESET_PC(16'h0100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ibus_req      (ibus_req),
    .ibus_addr     (ibus_addr),
    .ibus_ack      (ibus_ack),
    .ibus_rdata    (ibus_rdata),
    .ir            (ir),
    .pc            (pc),
    .dec_mem_read  (dec_mem_read),
    .dec_mem_write (dec_mem_write),
    .dec_bra       (dec_bra),
    .dec_jmp       (dec_jmp),
    .dec_ret       (dec_ret),
    .dec_cr_write  (dec_cr_write),
    .dec_gpr_write (dec_gpr_write),
    .branch_offset (branch_offset),
    .cmp_true      (cmp_true),
    .jmp_target    (jmp_target),
    .epc_in        (epc_in),
    .tvec          (tvec),
    .irq           (irq),
    .irq_en        (irq_en),
    .dbus_req      (dbus_req),
    .dbus_we       (dbus_we),
    .dbus_ack      (dbus_ack),
    .gpr_we        (gpr_we),
    .cr_we         (cr_we),
    .epc_we        (epc_we),
    .epc_out       (epc_out),
    .irq_ack       (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; always return just after the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Complete a fetch with immediate ack; returns in EXEC.
  task automatic fetch(input logic [15:0] ins);
    ibus_rdata = ins;
    ibus_ack   = 1'b1;
    step();
    ibus_ack   = 1'b0;
  endtask

  task automatic clear_dec();
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_bra       = 1'b0;
    dec_jmp       = 1'b0;
    dec_ret       = 1'b0;
    dec_cr_write  = 1'b0;
    dec_gpr_write = 1'b0;
    cmp_true      = 1'b0;
  endtask

  // Jump to an absolute address; returns in FETCH with pc = t.
  task automatic jump_to(input logic [15:0] t);
    fetch(16'h7000);
    dec_jmp    = 1'b1;
    jmp_target = t;
    step();
    clear_dec();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ibus_req", {31'd0, ibus_req}, 32'd0);
    check("rst_pc", {16'd0, pc}, 32'h0100);
    check("rst_ir", {16'd0, ir}, 32'h0000);
    check("rst_dbus_req", {31'd0, dbus_req}, 32'd0);
    check("rst_gpr_we", {31'd0, gpr_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_ibus_req", {31'd0, ibus_req}, 32'd1);
    check("post_rst_addr", {16'd0, ibus_addr}, 32'h0100);

    // First ALU instruction, immediate ack; a stray ack in EXEC must be ignored
    fetch(16'hA5A5);
    check("alu_ir", {16'd0, ir}, 32'hA5A5);
    check("alu_exec_ibus_req", {31'd0, ibus_req}, 32'd0);
    dec_gpr_write = 1'b1;
    dec_cr_write  = 1'b1;
    ibus_ack      = 1'b1;
    ibus_rdata    = 16'hDEAD;
    #1;
    check("alu_gpr_we", {31'd0, gpr_we}, 32'd1);
    check("alu_cr_we", {31'd0, cr_we}, 32'd1);
    check("alu_pc_hold", {16'd0, pc}, 32'h0100);
    step();
    ibus_ack = 1'b0;
    clear_dec();
    #1;
    check("alu_pc_next", {16'd0, pc}, 32'h0102);
    check("alu_gpr_we_once", {31'd0, gpr_we}, 32'd0);
    check("alu_cr_we_once", {31'd0, cr_we}, 32'd0);
    check("alu_ir_stray_ack", {16'd0, ir}, 32'hA5A5);

    // Branch taken backwards
    jump_to(16'h0010);
    check("jmp_0010", {16'd0, ibus_addr}, 32'h0010);
    fetch(16'h1111);
    dec_bra = 1'b1; cmp_true = 1'b1; branch_offset = 16'hFFF8;
    step();
    clear_dec();
    check("bra_taken", {16'd0, ibus_addr}, 32'h0008);

    // Branch not taken
    jump_to(16'h0010);
    fetch(16'h1111);
    dec_bra = 1'b1; cmp_true = 1'b0;
    step();
    clear_dec();
    check("bra_not_taken", {16'd0, ibus_addr}, 32'h0012);

    // Sequential wrap at top of address space
    jump_to(16'hFFFE);
    fetch(16'h1111);
    dec_bra = 1'b1; cmp_true = 1'b0;
    step();
    clear_dec();
    check("pc_wrap", {16'd0, ibus_addr}, 32'h0000);

    // JMP beats a taken branch
    fetch(16'h2222);
    dec_jmp = 1'b1; jmp_target = 16'h1234;
    dec_bra = 1'b1; cmp_true = 1'b1; branch_offset = 16'h0100;
    step();
    clear_dec();
    check("jmp_over_bra", {16'd0, ibus_addr}, 32'h1234);

    // RET beats JMP and a taken branch
    fetch(16'h3333);
    dec_ret = 1'b1; epc_in = 16'h0200;
    dec_jmp = 1'b1; jmp_target = 16'h5555;
    dec_bra = 1'b1; cmp_true = 1'b1;
    step();
    clear_dec();
    check("ret_over_jmp_bra", {16'd0, ibus_addr}, 32'h0200);

    // Load with ack delayed three cycles
    fetch(16'h4444);
    dec_mem_read = 1'b1; dec_gpr_write = 1'b1;
    #1;
    check("ld_exec_gpr_we", {31'd0, gpr_we}, 32'd0);
    check("ld_exec_dbus_req", {31'd0, dbus_req}, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      check("ld_wait_dbus_req", {31'd0, dbus_req}, 32'd1);
      check("ld_wait_dbus_we", {31'd0, dbus_we}, 32'd0);
      check("ld_wait_gpr_we", {31'd0, gpr_we}, 32'd0);
      check("ld_wait_pc", {16'd0, pc}, 32'h0200);
      step();
    end
    dbus_ack = 1'b1;
    #1;
    check("ld_ack_dbus_req", {31'd0, dbus_req}, 32'd1);
    check("ld_ack_gpr_we", {31'd0, gpr_we}, 32'd1);
    step();
    dbus_ack = 1'b0;
    clear_dec();
    #1;
    check("ld_done_pc", {16'd0, pc}, 32'h0202);
    check("ld_done_gpr_we", {31'd0, gpr_we}, 32'd0);
    check("ld_done_dbus_req", {31'd0, dbus_req}, 32'd0);
    check("ld_done_ibus_req", {31'd0, ibus_req}, 32'd1);

    // Store: never writes the register file
    fetch(16'h5555);
    dec_mem_write = 1'b1;
    #1;
    check("st_exec_gpr_we", {31'd0, gpr_we}, 32'd0);
    step();
    check("st_dbus_we", {31'd0, dbus_we}, 32'd1);
    dbus_ack = 1'b1;
    #1;
    check("st_ack_gpr_we", {31'd0, gpr_we}, 32'd0);
    step();
    dbus_ack = 1'b0;
    clear_dec();
    check("st_done_pc", {16'd0, pc}, 32'h0204);

    // Interrupt raised during MEM, enabled
    fetch(16'h4444);
    dec_mem_read = 1'b1; dec_gpr_write = 1'b1;
    step();
    irq = 1'b1; irq_en = 1'b1;
    step();
    check("irq_mem_not_aborted", {31'd0, dbus_req}, 32'd1);
    dbus_ack = 1'b1;
    step();
    dbus_ack = 1'b0;
    clear_dec();
    #1;
    check("trap_epc_we", {31'd0, epc_we}, 32'd1);
    check("trap_irq_ack", {31'd0, irq_ack}, 32'd1);
    check("trap_epc_out", {16'd0, epc_out}, 32'h0206);
    check("trap_ibus_req", {31'd0, ibus_req}, 32'd0);
    check("trap_gpr_we", {31'd0, gpr_we}, 32'd0);
    irq = 1'b0;
    step();
    check("trap_vector", {16'd0, ibus_addr}, 32'h0040);
    check("trap_irq_ack_once", {31'd0, irq_ack}, 32'd0);
    check("trap_epc_we_once", {31'd0, epc_we}, 32'd0);

    // Interrupt raised during MEM, disabled
    fetch(16'h4444);
    dec_mem_read = 1'b1; dec_gpr_write = 1'b1;
    step();
    irq = 1'b1; irq_en = 1'b0;
    dbus_ack = 1'b1;
    step();
    dbus_ack = 1'b0;
    clear_dec();
    #1;
    check("noirq_irq_ack", {31'd0, irq_ack}, 32'd0);
    check("noirq_epc_we", {31'd0, epc_we}, 32'd0);
    check("noirq_fetch", {16'd0, ibus_addr}, 32'h0042);
    check("noirq_ibus_req", {31'd0, ibus_req}, 32'd1);
    irq = 1'b0;

    // Asynchronous reset during a stalled MEM
    fetch(16'h4444);
    dec_mem_read = 1'b1; dec_gpr_write = 1'b1;
    step();
    check("rstmem_dbus_req_pre", {31'd0, dbus_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmem_dbus_req", {31'd0, dbus_req}, 32'd0);
    check("rstmem_pc", {16'd0, pc}, 32'h0100);
    check("rstmem_gpr_we", {31'd0, gpr_we}, 32'd0);
    check("rstmem_ibus_req", {31'd0, ibus_req}, 32'd0);
    clear_dec();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rstmem_restart_req", {31'd0, ibus_req}, 32'd1);
    check("rstmem_restart_addr", {16'd0, ibus_addr}, 32'h0100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
